// File: rtl/dsp_macc_pkg.sv
// dsp_macc_pkg: shared mode encoding and saturation limit helper for the DSP MAC.
package dsp_macc_pkg;

   typedef enum logic [1:0] {
      MODE_MULT      = 2'b00,
      MODE_SHIFT_FB  = 2'b01,
      MODE_ACCUM     = 2'b10,
      MODE_SHIFT_ADD = 2'b11
   } macc_mode_t;

   localparam int SAT_MAX_W = 64;

   // All-ones upper clamp for a w-bit accumulator; the lower clamp is zero.
   function automatic logic [SAT_MAX_W-1:0] sat_max(input int unsigned w);
      return (w >= SAT_MAX_W) ? '1 : (SAT_MAX_W'(1) << w) - SAT_MAX_W'(1);
   endfunction

endpackage

// File: rtl/dsp_macc_in_stage.sv
// dsp_macc_in_stage: optional operand/valid register in front of the compute stage.
module dsp_macc_in_stage
   import dsp_macc_pkg::*;
#(
   parameter int A_W     = 20,
   parameter int B_W     = 18,
   parameter int SHIFT_W = 6,
   parameter int IN_REG  = 0
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_clear,
   input  logic               i_valid,
   input  logic [A_W-1:0]     i_a,
   input  logic [B_W-1:0]     i_b,
   input  logic [SHIFT_W-1:0] i_acc_fir,
   input  macc_mode_t         i_mode,
   input  logic               i_subtract,
   output logic               o_valid,
   output logic [A_W-1:0]     o_a,
   output logic [B_W-1:0]     o_b,
   output logic [SHIFT_W-1:0] o_acc_fir,
   output macc_mode_t         o_mode,
   output logic               o_subtract
);

   if (IN_REG != 0) begin : g_reg
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            o_valid    <= 1'b0;
            o_a        <= '0;
            o_b        <= '0;
            o_acc_fir  <= '0;
            o_mode     <= MODE_MULT;
            o_subtract <= 1'b0;
         end else begin
            o_valid    <= i_valid & ~i_clear;
            o_a        <= i_a;
            o_b        <= i_b;
            o_acc_fir  <= i_acc_fir;
            o_mode     <= i_mode;
            o_subtract <= i_subtract;
         end
      end
   end else begin : g_pass
      logic w_unused;
      assign w_unused   = ^{i_clk, i_rst_n, i_clear};
      assign o_valid    = i_valid;
      assign o_a        = i_a;
      assign o_b        = i_b;
      assign o_acc_fir  = i_acc_fir;
      assign o_mode     = i_mode;
      assign o_subtract = i_subtract;
   end

endmodule

// File: rtl/dsp_mult_add_shift_macc.sv
// dsp_mult_add_shift_macc: multiply / shift-add / accumulate unit with registered
// output, optional input register, valid pulse and sticky overflow.
module dsp_mult_add_shift_macc
   import dsp_macc_pkg::*;
#(
   parameter int A_W     = 20,
   parameter int B_W     = 18,
   parameter int Z_W     = 38,
   parameter int SHIFT_W = 6,
   parameter int IN_REG  = 0,
   parameter int SAT_EN  = 0
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_in_valid,
   input  logic [A_W-1:0]     i_a,
   input  logic [B_W-1:0]     i_b,
   input  logic [SHIFT_W-1:0] i_acc_fir,
   input  logic [1:0]         i_mode,
   input  logic               i_subtract,
   input  logic               i_clear,
   output logic [Z_W-1:0]     o_z_out,
   output logic               o_out_valid,
   output logic               o_overflow
);

   localparam logic [Z_W-1:0] Z_MAX = Z_W'(sat_max(Z_W));
   localparam logic [Z_W-1:0] Z_MIN = '0;

   logic               w_valid;
   logic [A_W-1:0]     w_a;
   logic [B_W-1:0]     w_b;
   logic [SHIFT_W-1:0] w_sh;
   macc_mode_t         w_mode;
   logic               w_sub;
   logic [Z_W-1:0]     w_s;
   logic [Z_W-1:0]     w_p;
   logic [Z_W-1:0]     w_fb;
   logic [Z_W:0]       w_acc;
   logic               w_ovf;
   logic [Z_W-1:0]     w_next;
   logic [Z_W-1:0]     r_z;
   logic               r_vld;
   logic               r_ovf;

   dsp_macc_in_stage #(
      .A_W    (A_W),
      .B_W    (B_W),
      .SHIFT_W(SHIFT_W),
      .IN_REG (IN_REG)
   ) u_in_stage (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_clear   (i_clear),
      .i_valid   (i_in_valid),
      .i_a       (i_a),
      .i_b       (i_b),
      .i_acc_fir (i_acc_fir),
      .i_mode    (macc_mode_t'(i_mode)),
      .i_subtract(i_subtract),
      .o_valid   (w_valid),
      .o_a       (w_a),
      .o_b       (w_b),
      .o_acc_fir (w_sh),
      .o_mode    (w_mode),
      .o_subtract(w_sub)
   );

   // Shift amounts at or beyond the accumulator width yield zero explicitly.
   assign w_s   = (32'(w_sh) >= 32'(Z_W)) ? '0 : Z_W'(w_a) << w_sh;
   assign w_p   = Z_W'(w_a) * Z_W'(w_b);
   assign w_fb  = Z_W'(r_z[A_W-1:0]) * Z_W'(w_b);
   assign w_acc = w_sub ? {1'b0, r_z} - {1'b0, w_p} : {1'b0, r_z} + {1'b0, w_p};
   assign w_ovf = w_acc[Z_W];

   always_comb begin
      w_next = (w_mode == MODE_MULT)      ? w_p :
               (w_mode == MODE_SHIFT_FB)  ? w_s + w_fb :
               (w_mode == MODE_SHIFT_ADD) ? w_s + w_p :
               (w_ovf && SAT_EN != 0)     ? (w_sub ? Z_MIN : Z_MAX) :
                                            w_acc[Z_W-1:0];
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_z   <= '0;
         r_vld <= 1'b0;
         r_ovf <= 1'b0;
      end else if (i_clear) begin
         r_z   <= '0;
         r_vld <= 1'b0;
         r_ovf <= 1'b0;
      end else if (w_valid) begin
         r_z   <= w_next;
         r_vld <= 1'b1;
         r_ovf <= r_ovf | (w_mode == MODE_ACCUM && w_ovf);
      end else begin
         r_vld <= 1'b0;
      end
   end

   assign o_z_out     = r_z;
   assign o_out_valid = r_vld;
   assign o_overflow  = r_ovf;

endmodule

// File: tb/tb_dsp_mult_add_shift_macc.sv
// tb_dsp_mult_add_shift_macc: directed vector table for the unregistered-input
// wrap/saturate variants plus hand sequences for the registered-input variant.
module tb_dsp_mult_add_shift_macc;

   localparam logic [37:0] P    = 38'h3F_FFEC_0001;
   localparam logic [37:0] ONES = 38'h3F_FFFF_FFFF;

   typedef struct {
      logic        v;
      logic [19:0] a;
      logic [17:0] b;
      logic [5:0]  sh;
      logic [1:0]  m;
      logic        sub;
      logic        clr;
      logic [37:0] z0;
      logic        o0;
      logic [37:0] z1;
      logic        o1;
      logic        vl;
   } vec_t;

   logic        clk, rst_n, in_valid, subtract, clear;
   logic [19:0] a;
   logic [17:0] b;
   logic [5:0]  acc_fir;
   logic [1:0]  mode;
   logic [37:0] z0, z1, z2;
   logic        v0, v1, v2, o0, o1, o2;
   int          errs = 0;
   int          checks = 0;
   vec_t        tv[$];

   dsp_mult_add_shift_macc #(.IN_REG(0), .SAT_EN(0)) u_d0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .i_a(a), .i_b(b),
      .i_acc_fir(acc_fir), .i_mode(mode), .i_subtract(subtract), .i_clear(clear),
      .o_z_out(z0), .o_out_valid(v0), .o_overflow(o0));

   dsp_mult_add_shift_macc #(.IN_REG(0), .SAT_EN(1)) u_d1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .i_a(a), .i_b(b),
      .i_acc_fir(acc_fir), .i_mode(mode), .i_subtract(subtract), .i_clear(clear),
      .o_z_out(z1), .o_out_valid(v1), .o_overflow(o1));

   dsp_mult_add_shift_macc #(.IN_REG(1), .SAT_EN(0)) u_d2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .i_a(a), .i_b(b),
      .i_acc_fir(acc_fir), .i_mode(mode), .i_subtract(subtract), .i_clear(clear),
      .o_z_out(z2), .o_out_valid(v2), .o_overflow(o2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic v, input logic [19:0] fa, input logic [17:0] fb,
                               input logic [5:0] sh, input logic [1:0] m, input logic sub,
                               input logic clr, input logic [37:0] ez0, input logic eo0,
                               input logic [37:0] ez1, input logic eo1, input logic vl);
      vec_t r;
      r = '{v, fa, fb, sh, m, sub, clr, ez0, eo0, ez1, eo1, vl};
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drv(input logic v, input logic [19:0] da, input logic [17:0] db,
                      input logic [5:0] sh, input logic [1:0] m, input logic sub,
                      input logic clr);
      in_valid = v; a = da; b = db; acc_fir = sh; mode = m; subtract = sub; clear = clr;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // columns: valid a b shift mode sub clear | z0 ov0 (wrap) z1 ov1 (sat) out_valid
      tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      tv.push_back(mk(1, 3, 4, 0, 0, 0, 0, 12, 0, 12, 0, 1));
      tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      tv.push_back(mk(1, 255, 1, 1, 1, 0, 0, 510, 0, 510, 0, 1));
      tv.push_back(mk(1, 255, 1, 1, 1, 0, 0, 1020, 0, 1020, 0, 1));
      tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      tv.push_back(mk(1, 3, 4, 0, 0, 0, 0, 12, 0, 12, 0, 1));
      tv.push_back(mk(1, 1, 3, 0, 1, 0, 0, 37, 0, 37, 0, 1));
      tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      tv.push_back(mk(1, 20'hFFFFF, 18'h3FFFF, 0, 2, 0, 0, P, 0, P, 0, 1));
      tv.push_back(mk(1, 20'hFFFFF, 18'h3FFFF, 0, 2, 0, 0, 38'h3F_FFD8_0002, 1, ONES, 1, 1));
      tv.push_back(mk(1, 1, 1, 0, 2, 1, 0, 38'h3F_FFD8_0001, 1, 38'h3F_FFFF_FFFE, 1, 1));
      tv.push_back(mk(0, 9, 9, 0, 0, 0, 0, 38'h3F_FFD8_0001, 1, 38'h3F_FFFF_FFFE, 1, 0));
      tv.push_back(mk(1, 2, 3, 0, 0, 0, 0, 6, 1, 6, 1, 1));
      tv.push_back(mk(1, 5, 5, 0, 2, 1, 0, 38'h3F_FFFF_FFED, 1, 0, 1, 1));
      tv.push_back(mk(1, 5, 5, 0, 2, 0, 1, 0, 0, 0, 0, 0));
      tv.push_back(mk(1, 3, 2, 40, 3, 0, 0, 6, 0, 6, 0, 1));
      tv.push_back(mk(1, 3, 2, 2, 3, 0, 0, 18, 0, 18, 0, 1));
      tv.push_back(mk(1, 1, 1, 0, 2, 1, 0, 17, 0, 17, 0, 1));
      tv.push_back(mk(1, 5, 5, 0, 2, 1, 0, 38'h3F_FFFF_FFF8, 1, 0, 1, 1));
      tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      tv.push_back(mk(1, 1, 3, 37, 1, 0, 0, 38'h20_0000_0000, 0, 38'h20_0000_0000, 0, 1));
      tv.push_back(mk(1, 20'hFFFFF, 18'h3FFFF, 0, 2, 0, 0, 38'h1F_FFEC_0001, 1, ONES, 1, 1));
      tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      tv.push_back(mk(1, 20'hFFFFF, 18'h3FFFF, 18, 1, 0, 0, 38'h3F_FFFC_0000, 0, 38'h3F_FFFC_0000, 0, 1));
      tv.push_back(mk(1, 20'hFFFFF, 18'h3FFFF, 18, 3, 0, 0, 38'h3F_FFE8_0001, 0, 38'h3F_FFE8_0001, 0, 1));

      rst_n = 1'b0;
      drv(0, 0, 0, 0, 0, 0, 0);
      #12;
      chk("rst_d0", {z0, v0, o0}, 0);
      chk("rst_d1", {z1, v1, o1}, 0);
      chk("rst_d2", {z2, v2, o2}, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      foreach (tv[i]) begin
         drv(tv[i].v, tv[i].a, tv[i].b, tv[i].sh, tv[i].m, tv[i].sub, tv[i].clr);
         step();
         chk($sformatf("v%0d_z0", i), z0, tv[i].z0);
         chk($sformatf("v%0d_ov0", i), o0, tv[i].o0);
         chk($sformatf("v%0d_vld0", i), v0, tv[i].vl);
         chk($sformatf("v%0d_z1", i), z1, tv[i].z1);
         chk($sformatf("v%0d_ov1", i), o1, tv[i].o1);
         chk($sformatf("v%0d_vld1", i), v1, tv[i].vl);
      end

      // asynchronous reset mid-stream, between edges
      drv(1, 7, 7, 0, 0, 0, 0);
      step();
      chk("pre_rst_z0", z0, 49);
      drv(1, 5, 5, 0, 2, 0, 0);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_d0", {z0, v0, o0}, 0);
      chk("arst_d1", {z1, v1, o1}, 0);
      chk("arst_d2", {z2, v2, o2}, 0);
      drv(0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      drv(1, 3, 4, 0, 0, 0, 0);
      step();
      chk("post_rst_z0", z0, 12);
      chk("post_rst_vld0", v0, 1);
      chk("post_rst_z2_early", z2, 0);
      chk("post_rst_vld2_early", v2, 0);
      drv(0, 0, 0, 0, 0, 0, 0);
      step();
      chk("post_rst_z2", z2, 12);
      chk("post_rst_vld2", v2, 1);
      chk("post_rst_vld0_idle", v0, 0);

      // registered-input latency for a full-scale product
      drv(1, 20'hFFFFF, 18'h3FFFF, 0, 0, 0, 0);
      step();
      chk("big_z2_hold", z2, 12);
      chk("big_vld2_early", v2, 0);
      chk("big_z0", z0, P);
      drv(0, 0, 0, 0, 0, 0, 0);
      step();
      chk("big_z2", z2, P);
      chk("big_vld2", v2, 1);

      // clear with a valid operand: flushed operand must never reach z_out
      drv(1, 5, 5, 0, 2, 0, 1);
      step();
      chk("clr_d2", {z2, v2, o2}, 0);
      chk("clr_d0", {z0, v0, o0}, 0);
      drv(0, 0, 0, 0, 0, 0, 0);
      step();
      chk("flush_z2", z2, 0);
      chk("flush_vld2", v2, 0);

      // back-to-back feedback through the registered input
      drv(1, 255, 1, 1, 1, 0, 0);
      step();
      chk("fb2_vld_early", v2, 0);
      step();
      chk("fb2_z_1", z2, 510);
      chk("fb2_vld_1", v2, 1);
      drv(0, 0, 0, 0, 0, 0, 0);
      step();
      chk("fb2_z_2", z2, 1020);
      chk("fb2_vld_2", v2, 1);

      // borrow wraps and sets the sticky flag
      drv(1, 1, 1021, 0, 2, 1, 0);
      step();
      drv(0, 0, 0, 0, 0, 0, 0);
      step();
      chk("wrap2_z", z2, ONES);
      chk("wrap2_ov", o2, 1);
      step();
      chk("wrap2_vld_idle", v2, 0);
      chk("wrap2_ov_sticky", o2, 1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
